// File: rtl/control_pkg.sv
// Shared types for the game-core command front-end:
// the control_type command set and the UART key decoder.
package control_pkg;

    localparam int CMD_W = 3;

    typedef enum logic [CMD_W-1:0] {
        NONE       = 3'd0,
        LEFT       = 3'd1,
        RIGHT      = 3'd2,
        DOWN       = 3'd3,
        DROP       = 3'd4,
        HOLD       = 3'd5,
        ROTATE     = 3'd6,
        ROTATE_REV = 3'd7
    } control_type;

    function automatic control_type decode_key(input logic [7:0] b);
        control_type c;
        unique case (b)
            "A", "a": c = LEFT;
            "D", "d": c = RIGHT;
            "W", "w": c = DOWN;
            "S", "s": c = DROP;
            "C", "c": c = HOLD;
            "X", "x": c = ROTATE;
            "Z", "z": c = ROTATE_REV;
            default:  c = NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/control_fifo.sv
// Command FIFO with wrap-bit pointers; drop_head discards the
// head so a push into a full FIFO can evict the oldest entry.
module control_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   push,
    input  logic [W-1:0]           din,
    input  logic                   pop,
    input  logic                   drop_head,
    output logic [W-1:0]           dout,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic         do_adv;
    logic         do_push;

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (count == '0);
    assign full    = count[AW];
    assign do_adv  = (pop || drop_head) && !empty;
    assign do_push = push && (!full || do_adv);
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer update; clear flushes regardless of push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_adv)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; a full push+evict reuses the evicted head slot.
    always_ff @(posedge clk) begin
        if (!clear && do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/control_queue.sv
// Merges UART keys and button pulses through per-source pending
// latches and a round-robin arbiter into the command FIFO.
module control_queue
    import control_pkg::*;
#(
    parameter int                     DEPTH       = 16,
    parameter int                     N_BTN       = 4,
    parameter logic [N_BTN*CMD_W-1:0] BTN_MAP     = {LEFT, ROTATE, HOLD, RIGHT},
    parameter bit                     DROP_OLDEST = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_byte,
    input  logic [N_BTN-1:0]       btn_pulse,
    output logic [CMD_W-1:0]       cmd,
    output logic                   cmd_valid,
    input  logic                   cmd_ready,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic [7:0]             overflow_cnt
);

    localparam int NS = N_BTN + 1;
    localparam int PW = $clog2(NS);

    logic [NS-1:0]    ev_vld;
    logic [CMD_W-1:0] ev_cmd   [NS];
    logic [NS-1:0]    pend_vld;
    logic [CMD_W-1:0] pend_cmd [NS];
    logic [PW-1:0]    ptr;
    logic             gnt;
    logic [PW-1:0]    gnt_idx;
    logic [CMD_W-1:0] gnt_cmd;
    logic             full;
    logic             empty;
    logic             pop;
    logic             can_grant;
    logic             drop_head;
    logic [7:0]       n_lost;
    logic [8:0]       cnt_sum;
    control_type      key_cmd;

    assign key_cmd   = decode_key(rx_byte);
    assign cmd_valid = !empty;
    assign pop       = cmd_valid && cmd_ready && !clear;
    assign can_grant = !clear && (!full || pop || DROP_OLDEST);
    assign drop_head = gnt && full && !pop && DROP_OLDEST;
    assign cnt_sum   = {1'b0, overflow_cnt} + {1'b0, n_lost};

    // Event decode: buttons first, UART key is the last source.
    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            ev_cmd[i] = BTN_MAP[i*CMD_W +: CMD_W];
            ev_vld[i] = btn_pulse[i] && (ev_cmd[i] != NONE);
        end
        ev_cmd[N_BTN] = key_cmd;
        ev_vld[N_BTN] = rx_valid && (key_cmd != NONE);
    end

    // Round-robin pick of one occupied latch starting at ptr.
    always_comb begin : arb
        int j;
        j       = 0;
        gnt     = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NS; k++) begin
            j = int'(ptr) + k;
            if (j >= NS) j = j - NS;
            if (!gnt && can_grant && pend_vld[j]) begin
                gnt     = 1'b1;
                gnt_idx = PW'(j);
            end
        end
        gnt_cmd = pend_cmd[gnt_idx];
    end

    // Lost events: busy latches plus an evicted head.
    always_comb begin
        n_lost = '0;
        for (int i = 0; i < NS; i++) begin
            if (ev_vld[i] && pend_vld[i] && !(gnt && gnt_idx == PW'(i)))
                n_lost = n_lost + 8'd1;
        end
        if (drop_head) n_lost = n_lost + 8'd1;
        if (clear)     n_lost = '0;
    end

    // Pending latches, arbiter pointer and overflow bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_vld     <= '0;
            ptr          <= '0;
            overflow     <= 1'b0;
            overflow_cnt <= '0;
            for (int i = 0; i < NS; i++) pend_cmd[i] <= '0;
        end else begin
            overflow     <= (n_lost != '0);
            overflow_cnt <= cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
            if (clear) begin
                pend_vld <= '0;
            end else begin
                for (int i = 0; i < NS; i++) begin
                    if (ev_vld[i] && (!pend_vld[i] ||
                        (gnt && gnt_idx == PW'(i)))) begin
                        pend_vld[i] <= 1'b1;
                        pend_cmd[i] <= ev_cmd[i];
                    end else if (gnt && gnt_idx == PW'(i)) begin
                        pend_vld[i] <= 1'b0;
                    end
                end
                if (gnt)
                    ptr <= (gnt_idx == PW'(NS - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

    control_fifo #(
        .DEPTH (DEPTH),
        .W     (CMD_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .push      (gnt),
        .din       (gnt_cmd),
        .pop       (pop),
        .drop_head (drop_head),
        .dout      (cmd),
        .empty     (empty),
        .full      (full),
        .count     (count)
    );

endmodule

// File: tb/tb_control_queue.sv
// Directed bench: instance A keeps incoming on overflow,
// instance B drops the oldest; both have DEPTH=4.
module tb_control_queue;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       a_clear = 0, a_rx_valid = 0, a_ready = 0;
    logic [7:0] a_rx_byte = 0;
    logic [3:0] a_btn = 0;
    logic [2:0] a_cmd, a_count;
    logic       a_vld, a_ovf;
    logic [7:0] a_ocnt;

    logic       b_clear = 0, b_rx_valid = 0, b_ready = 0;
    logic [7:0] b_rx_byte = 0;
    logic [3:0] b_btn = 0;
    logic [2:0] b_cmd, b_count;
    logic       b_vld, b_ovf;
    logic [7:0] b_ocnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    control_queue #(.DEPTH(4), .DROP_OLDEST(1'b0)) ua (
        .clk(clk), .rst(rst), .clear(a_clear),
        .rx_valid(a_rx_valid), .rx_byte(a_rx_byte), .btn_pulse(a_btn),
        .cmd(a_cmd), .cmd_valid(a_vld), .cmd_ready(a_ready),
        .count(a_count), .overflow(a_ovf), .overflow_cnt(a_ocnt)
    );

    control_queue #(.DEPTH(4), .DROP_OLDEST(1'b1)) ub (
        .clk(clk), .rst(rst), .clear(b_clear),
        .rx_valid(b_rx_valid), .rx_byte(b_rx_byte), .btn_pulse(b_btn),
        .cmd(b_cmd), .cmd_valid(b_vld), .cmd_ready(b_ready),
        .count(b_count), .overflow(b_ovf), .overflow_cnt(b_ocnt)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_cmd",   32'(a_cmd),   0);
        chk("rst_vld",   32'(a_vld),   0);
        chk("rst_count", 32'(a_count), 0);
        chk("rst_ovf",   32'(a_ovf),   0);
        chk("rst_ocnt",  32'(a_ocnt),  0);

        // single key 'a' -> LEFT after two edges
        a_rx_valid = 1; a_rx_byte = "a";
        cyc();
        a_rx_valid = 0;
        chk("lat_vld0", 32'(a_vld), 0);
        cyc();
        chk("a_vld",   32'(a_vld),   1);
        chk("a_cmd",   32'(a_cmd),   1);
        chk("a_count", 32'(a_count), 1);
        a_ready = 1;
        cyc();
        a_ready = 0;
        chk("pop_cmd",   32'(a_cmd),   0);
        chk("pop_count", 32'(a_count), 0);

        // simultaneous btn0, btn3 and 'x'
        a_btn = 4'b1001; a_rx_valid = 1; a_rx_byte = "x";
        cyc();
        a_btn = 0; a_rx_valid = 0;
        chk("rr_ovf0", 32'(a_ovf), 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rr_ovf", 32'(a_ovf), 0);
        end
        chk("rr_count", 32'(a_count), 3);
        a_ready = 1;
        chk("rr_0", 32'(a_cmd), 2);
        cyc();
        chk("rr_1", 32'(a_cmd), 1);
        cyc();
        chk("rr_2", 32'(a_cmd), 6);
        cyc();
        chk("rr_empty", 32'(a_vld), 0);
        cyc();
        chk("no_underflow", 32'(a_count), 0);
        a_ready = 0;

        // six 'd' into DEPTH=4, keep incoming policy
        a_rx_valid = 1; a_rx_byte = "d";
        repeat (6) cyc();
        a_rx_valid = 0;
        chk("full_count", 32'(a_count), 4);
        chk("full_ovf",   32'(a_ovf),   1);
        chk("full_ocnt",  32'(a_ocnt),  1);
        cyc();
        chk("ovf_pulse_end", 32'(a_ovf),   0);
        chk("held_count",    32'(a_count), 4);
        a_ready = 1;
        cyc();
        a_ready = 0;
        chk("held_in_count", 32'(a_count), 4);
        chk("held_in_ocnt",  32'(a_ocnt),  1);
        cyc();
        chk("held_settle", 32'(a_count), 4);
        chk("held_head",   32'(a_cmd),   2);

        // full FIFO: grant and pop in the same cycle
        a_btn = 4'b0010;
        cyc();
        a_btn = 0;
        chk("hold_wait_count", 32'(a_count), 4);
        a_ready = 1;
        cyc();
        chk("pp_count", 32'(a_count), 4);
        chk("pp_ovf",   32'(a_ovf),   0);
        chk("pp_ocnt",  32'(a_ocnt),  1);
        chk("pp_h0",    32'(a_cmd),   2);
        cyc();
        chk("pp_h1", 32'(a_cmd), 2);
        cyc();
        chk("pp_h2", 32'(a_cmd), 2);
        cyc();
        chk("pp_h3", 32'(a_cmd), 5);
        cyc();
        chk("pp_empty", 32'(a_vld), 0);
        a_ready = 0;

        // unmapped byte
        a_rx_valid = 1; a_rx_byte = "q";
        cyc();
        a_rx_valid = 0;
        cyc();
        chk("q_count", 32'(a_count), 0);
        chk("q_ocnt",  32'(a_ocnt),  1);

        // clear beats a same-cycle button event
        a_rx_valid = 1; a_rx_byte = "w";
        cyc();
        a_rx_valid = 0;
        cyc();
        chk("w_count", 32'(a_count), 1);
        chk("w_cmd",   32'(a_cmd),   3);
        a_clear = 1; a_btn = 4'b0001;
        cyc();
        a_clear = 0; a_btn = 0;
        chk("clr_count", 32'(a_count), 0);
        chk("clr_vld",   32'(a_vld),   0);
        chk("clr_ocnt",  32'(a_ocnt),  1);
        cyc();
        chk("clr_discard", 32'(a_count), 0);

        // B: drop-oldest overflow
        b_rx_valid = 1;
        b_rx_byte = "W"; cyc();
        b_rx_byte = "S"; cyc();
        b_rx_byte = "C"; cyc();
        b_rx_byte = "Z"; cyc();
        b_rx_byte = "X"; cyc();
        b_rx_valid = 0;
        cyc();
        chk("b_count", 32'(b_count), 4);
        chk("b_ovf",   32'(b_ovf),   1);
        chk("b_ocnt",  32'(b_ocnt),  1);
        b_ready = 1;
        chk("b_h0", 32'(b_cmd), 4);
        cyc();
        chk("b_h1", 32'(b_cmd), 5);
        cyc();
        chk("b_h2", 32'(b_cmd), 7);
        cyc();
        chk("b_h3", 32'(b_cmd), 6);
        cyc();
        chk("b_empty", 32'(b_vld), 0);
        b_ready = 0;

        // asynchronous reset mid-stream
        a_rx_valid = 1; a_rx_byte = "a";
        cyc();
        a_rx_valid = 0;
        cyc();
        chk("pre_rst_count", 32'(a_count), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_count", 32'(a_count), 0);
        chk("arst_vld",   32'(a_vld),   0);
        chk("arst_cmd",   32'(a_cmd),   0);
        chk("arst_ocnt",  32'(a_ocnt),  0);
        chk("arst_bocnt", 32'(b_ocnt),  0);
        @(posedge clk);
        #1 rst = 1'b0;
        cyc();
        chk("post_rst_count", 32'(a_count), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
